// File: rtl/param_mul_div_unit_pkg.sv
// Shared execution-stage types: MDU operation encoding, MDU FSM states and
// decoded control bundle, plus MDU operation-class predicates.
package param_mul_div_unit_pkg;

  localparam int unsigned MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MADD  = 4'd5,
    MADDU = 4'd6,
    MSUB  = 4'd7,
    MSUBU = 4'd8,
    MTHI  = 4'd9,
    MTLO  = 4'd10,
    MFHI  = 4'd11,
    MFLO  = 4'd12
  } mdu_operation_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } mdu_state_t;

  typedef struct packed {
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           branch;
    logic           alu_src;
    mdu_operation_t mdu_op;
  } control_signals_t;

  // Operations that run for MUL_LATENCY cycles.
  function automatic logic isMulClass(input mdu_operation_t op);
    case (op)
      MULT, MULTU, MADD, MADDU, MSUB, MSUBU: isMulClass = 1'b1;
      default:                               isMulClass = 1'b0;
    endcase
  endfunction

  // Operations that run for DIV_LATENCY cycles.
  function automatic logic isDivClass(input mdu_operation_t op);
    case (op)
      DIV, DIVU: isDivClass = 1'b1;
      default:   isDivClass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: produces the {HI,LO} image for multiply,
// accumulate and divide ops, with fixed divide-by-zero and overflow results.
module mdu_arith
  import param_mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mdu_operation_t     i_op,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [2*WIDTH-1:0] o_result_c
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic [W2-1:0] w_acc;
  logic [W2-1:0] w_a_s;
  logic [W2-1:0] w_b_s;
  logic [W2-1:0] w_a_u;
  logic [W2-1:0] w_b_u;
  logic [W2-1:0] w_prod_s;
  logic [W2-1:0] w_prod_u;

  logic signed [WIDTH-1:0] w_s1;
  logic signed [WIDTH-1:0] w_s2;
  logic signed [WIDTH-1:0] w_sq;
  logic signed [WIDTH-1:0] w_sr;
  logic        [WIDTH-1:0] w_uq;
  logic        [WIDTH-1:0] w_ur;
  logic                    w_div_zero;
  logic                    w_div_ovf;

  assign w_acc = {i_hi, i_lo};

  // Sign-extended operands multiplied at 2*WIDTH give the exact signed product.
  assign w_a_s    = {{WIDTH{i_op1[WIDTH-1]}}, i_op1};
  assign w_b_s    = {{WIDTH{i_op2[WIDTH-1]}}, i_op2};
  assign w_a_u    = {{WIDTH{1'b0}}, i_op1};
  assign w_b_u    = {{WIDTH{1'b0}}, i_op2};
  assign w_prod_s = w_a_s * w_b_s;
  assign w_prod_u = w_a_u * w_b_u;

  assign w_s1 = $signed(i_op1);
  assign w_s2 = $signed(i_op2);
  assign w_sq = w_s1 / w_s2;
  assign w_sr = w_s1 % w_s2;
  assign w_uq = i_op1 / i_op2;
  assign w_ur = i_op1 % i_op2;

  assign w_div_zero = (i_op2 == {WIDTH{1'b0}});
  assign w_div_ovf  = (i_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_op2 == {WIDTH{1'b1}});

  // Result layout is {HI, LO}; divides place remainder in HI, quotient in LO.
  always_comb begin
    o_result_c = {W2{1'b0}};
    case (i_op)
      MULT:  o_result_c = w_prod_s;
      MULTU: o_result_c = w_prod_u;
      MADD:  o_result_c = w_acc + w_prod_s;
      MADDU: o_result_c = w_acc + w_prod_u;
      MSUB:  o_result_c = w_acc - w_prod_s;
      MSUBU: o_result_c = w_acc - w_prod_u;
      DIV: begin
        if (w_div_zero) begin
          o_result_c = {i_op1, {WIDTH{1'b1}}};
        end else if (w_div_ovf) begin
          o_result_c = {{WIDTH{1'b0}}, i_op1};
        end else begin
          o_result_c = {w_sr, w_sq};
        end
      end
      DIVU: begin
        if (w_div_zero) begin
          o_result_c = {i_op1, {WIDTH{1'b1}}};
        end else begin
          o_result_c = {w_ur, w_uq};
        end
      end
      default: o_result_c = {W2{1'b0}};
    endcase
  end

endmodule

// File: rtl/param_mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: result is computed at
// launch, held pending for the op latency, then committed unless flushed.
module param_mul_div_unit
  import param_mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 5,
  parameter int unsigned DIV_LATENCY = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  mdu_operation_t   operation,
  input  logic             start,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] dataRead,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2      = 2 * WIDTH;
  localparam int unsigned MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  mdu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [W2-1:0]    r_pending;
  logic             r_busy;

  mdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [W2-1:0]    w_pending_nxt;
  logic             w_busy_nxt;
  logic [W2-1:0]    w_result;
  logic             w_launch;

  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .i_op       (operation),
    .i_op1      (operand1),
    .i_op2      (operand2),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_result_c (w_result)
  );

  assign w_launch = start && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pending <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pending <= w_pending_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Flush beats both launch and commit; start is ignored outside IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pending_nxt = r_pending;
    w_busy_nxt    = r_busy;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          if (isMulClass(operation)) begin
            w_pending_nxt = w_result;
            w_cnt_nxt     = CNT_W'(MUL_LATENCY - 1);
            w_state_nxt   = MUL_RUN;
            w_busy_nxt    = 1'b1;
          end else if (isDivClass(operation)) begin
            w_pending_nxt = w_result;
            w_cnt_nxt     = CNT_W'(DIV_LATENCY - 1);
            w_state_nxt   = DIV_RUN;
            w_busy_nxt    = 1'b1;
          end else if (operation == MTHI) begin
            w_hi_nxt = operand1;
          end else if (operation == MTLO) begin
            w_lo_nxt = operand1;
          end
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (flush) begin
          w_state_nxt   = IDLE;
          w_busy_nxt    = 1'b0;
          w_pending_nxt = '0;
          w_cnt_nxt     = '0;
        end else if (r_cnt == '0) begin
          w_hi_nxt    = r_pending[W2-1:WIDTH];
          w_lo_nxt    = r_pending[WIDTH-1:0];
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Move-from reads bypass the FSM so they never stall.
  always_comb begin
    dataRead = '0;
    case (operation)
      MFHI:    dataRead = r_hi;
      MFLO:    dataRead = r_lo;
      default: dataRead = '0;
    endcase
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_param_mul_div_unit.sv
// Directed bench for param_mul_div_unit (WIDTH=32, MUL=5, DIV=10) with
// hand-computed HI/LO, busy-length, flush and reset expectations.
module tb_param_mul_div_unit;
  import param_mul_div_unit_pkg::*;

  logic           clock;
  logic           reset;
  logic [31:0]    operand1;
  logic [31:0]    operand2;
  mdu_operation_t operation;
  logic           start;
  logic           flush;
  logic           busy;
  logic [31:0]    dataRead;
  logic [31:0]    hi;
  logic [31:0]    lo;

  int n_checks;
  int n_pass;
  int cyc;

  param_mul_div_unit #(
    .WIDTH       (32),
    .MUL_LATENCY (5),
    .DIV_LATENCY (10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
    .start     (start),
    .flush     (flush),
    .busy      (busy),
    .dataRead  (dataRead),
    .hi        (hi),
    .lo        (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one op at the next edge, then count cycles with busy high.
  task automatic run_op(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clock);
    operation = op;
    operand1  = a;
    operand2  = b;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    operation = NONE;
    cycles    = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clock);
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    int c;
    run_op(MTHI, h, 32'h0, c);
    run_op(MTLO, l, 32'h0, c);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    operation = NONE;
    operand1  = '0;
    operand2  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_hilo", {hi, lo}, 64'h0);

    // Signed multiply, latency and move-from reads
    run_op(MULT, 32'hFFFF_FFFE, 32'd3, cyc);
    check_eq("mult_cycles", 64'(cyc), 64'd5);
    check_eq("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    operation = MFHI;
    #1 check_eq("mfhi_data", 64'(dataRead), 64'hFFFF_FFFF);
    operation = MFLO;
    #1 check_eq("mflo_data", 64'(dataRead), 64'hFFFF_FFFA);
    operation = NONE;
    #1 check_eq("none_data", 64'(dataRead), 64'h0);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check_eq("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Divides
    run_op(DIVU, 32'd100, 32'd7, cyc);
    check_eq("divu_cycles", 64'(cyc), 64'd10);
    check_eq("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    check_eq("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, cyc);
    check_eq("div_negdiv_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_op(DIV, 32'h1234, 32'd0, cyc);
    check_eq("div_zero_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(DIVU, 32'd5, 32'd0, cyc);
    check_eq("divu_zero_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check_eq("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // Moves and accumulates
    run_op(MTHI, 32'h0, 32'h0, cyc);
    check_eq("mthi_cycles", 64'(cyc), 64'd0);
    run_op(MTLO, 32'hFFFF_FFFF, 32'h0, cyc);
    check_eq("mtlo_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    run_op(MADDU, 32'd1, 32'd1, cyc);
    check_eq("maddu_cycles", 64'(cyc), 64'd5);
    check_eq("maddu_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    set_hilo(32'h0, 32'h0);
    run_op(MSUB, 32'd1, 32'd1, cyc);
    check_eq("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(MADD, 32'hFFFF_FFFF, 32'd1, cyc);
    check_eq("madd_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    set_hilo(32'h0, 32'h0);
    run_op(MSUBU, 32'hFFFF_FFFF, 32'd2, cyc);
    check_eq("msubu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0002);

    // Start while busy is ignored
    @(negedge clock);
    operation = MULT; operand1 = 32'd2; operand2 = 32'd3; start = 1'b1;
    @(negedge clock);
    cyc = busy ? 1 : 0;
    operation = DIVU; operand1 = 32'd100; operand2 = 32'd7;
    @(negedge clock);
    start = 1'b0; operation = NONE;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clock);
    end
    check_eq("busy_start_cycles", 64'(cyc), 64'd5);
    check_eq("busy_start_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // Flush mid-run
    set_hilo(32'hAA, 32'hAA);
    @(negedge clock);
    operation = MULT; operand1 = 32'd5; operand2 = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0; operation = NONE;
    repeat (2) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_hilo", {hi, lo}, 64'h0000_00AA_0000_00AA);
    repeat (6) @(negedge clock);
    check_eq("flush_late_hilo", {hi, lo}, 64'h0000_00AA_0000_00AA);

    // Flush on the commit edge
    @(negedge clock);
    operation = MULT; operand1 = 32'd5; operand2 = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0; operation = NONE;
    repeat (4) @(negedge clock);
    check_eq("commit_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check_eq("commit_flush_busy", 64'(busy), 64'd0);
    check_eq("commit_flush_hilo", {hi, lo}, 64'h0000_00AA_0000_00AA);

    // Async reset mid-divide
    set_hilo(32'h55, 32'h66);
    @(negedge clock);
    operation = DIVU; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0; operation = NONE;
    @(negedge clock);
    check_eq("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1 check_eq("async_reset_busy", 64'(busy), 64'd0);
    check_eq("async_reset_hilo", {hi, lo}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check_eq("post_reset_hilo", {hi, lo}, 64'h0);

    // Start together with flush in IDLE, NONE and MFHI with start
    @(negedge clock);
    operation = MTLO; operand1 = 32'h77; start = 1'b1; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0; operation = NONE;
    check_eq("flush_mtlo_lo", 64'(lo), 64'h0);
    @(negedge clock);
    operation = MULT; operand1 = 32'd5; operand2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0; operation = NONE;
    check_eq("flush_mult_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clock);
    check_eq("flush_mult_hilo", {hi, lo}, 64'h0);
    run_op(NONE, 32'h1, 32'h1, cyc);
    check_eq("none_cycles", 64'(cyc), 64'd0);
    check_eq("none_hilo", {hi, lo}, 64'h0);
    run_op(MFHI, 32'h1, 32'h1, cyc);
    check_eq("mfhi_start_cycles", 64'(cyc), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/param_mul_div_unit.md
Name: param_mul_div_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the execution stage beside the ALU; its busy output feeds the stage stall.
- Generalises the fixed MDU with configurable data width and separate multiply/divide latencies.
- Adds MADD/MADDU/MSUB/MSUBU accumulate ops, an in-flight flush (cancel) and defined divide-by-zero and overflow results.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (>=8).
- MUL_LATENCY, 5, cycles busy for MULT/MULTU/MADD*/MSUB* (>=1).
- DIV_LATENCY, 10, cycles busy for DIV/DIVU (>=1).

Ports:
- clock  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- operand1  in  WIDTH  rs value, already forwarded.
- operand2  in  WIDTH  rt value, already forwarded.
- operation  in  mdu_operation_t  operation selector.
- start  in  1  launch operation; producer gates it with !stall.
- flush  in  1  abort in-flight op (branch/exception kill).
- busy  out  1  op in flight; stage must stall.
- dataRead  out  WIDTH  HI for MFHI, LO for MFLO, else 0.
- hi  out  WIDTH  architectural HI (debug/trace).
- lo  out  WIDTH  architectural LO (debug/trace).

Behaviour:
- Reset (async): state=IDLE, HI=0, LO=0, counter=0, busy=0, pending result=0.
- States are IDLE, MUL_RUN, DIV_RUN; busy = (state != IDLE), driven from a register.
- IDLE + start + MULT/MULTU/MADD*/MSUB* at edge E0:
  - compute the 2*WIDTH result from the E0 operands into a pending register;
  - load counter = MUL_LATENCY-1; go to MUL_RUN.
- IDLE + start + DIV/DIVU: same, with DIV_LATENCY-1; go to DIV_RUN.
- Latency: busy is high exactly LAT cycles after E0. At edge E_LAT, HI/LO take the pending value and state returns to IDLE.
  - MUL_LATENCY=1 gives a single busy cycle.
- Counting: counter decrements each cycle in a run state; commit when counter==0.
- Multiply: {HI,LO} = op1*op2 as 2*WIDTH bits; signed for MULT, zero-extended for MULTU.
- MADD/MADDU: {HI,LO} + product. MSUB/MSUBU: {HI,LO} - product.
  - HI/LO captured at E0, modulo 2^(2*WIDTH).
- Divide: LO=quotient, HI=remainder.
  - Signed: truncate toward zero; remainder takes the sign of the dividend.
  - Divide by zero: LO=all ones, HI=op1 (signed and unsigned).
  - Signed overflow (op1=most-negative, op2=-1): LO=op1, HI=0.
- MTHI/MTLO with start in IDLE: write HI/LO at E0; no busy cycle.
- MFHI/MFLO: dataRead is combinational from current HI/LO.
  - start is ignored for these; no state change.
- start while busy: ignored. Upstream must not assert it, since stall gates start.
- flush (has priority over everything):
  - in a run state: return to IDLE next edge, HI/LO unchanged, pending result discarded;
  - in IDLE: suppresses a same-cycle start, including MTHI/MTLO.
- flush on the commit edge (counter==0): commit is suppressed and HI/LO unchanged.
- Reset mid-operation: immediate IDLE, HI=LO=0.
- operation=NONE with start: no effect.

Decomposition:
- Shared package (same package as control_signals_t), holding:
  - mdu_operation_t enum: NONE, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO;
  - helper predicates isMulClass and isDivClass.
- One combinational sub-module, mdu_arith: takes operation, operands, HI and LO; returns the 2*WIDTH result, including the div-zero and overflow rules.
- Top level holds the FSM, counter and HI/LO registers.

Test Plan (WIDTH=32, MUL_LATENCY=5, DIV_LATENCY=10):
1. MULT 0xFFFFFFFE (-2) x 3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI dataRead=0xFFFFFFFF.
2. DIVU 100 / 7 -> busy 10 cycles; LO=14, HI=2. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIV by 0 with op1=0x1234 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI 0 and MTLO 0xFFFFFFFF, then MADDU 1 x 1 -> HI=1, LO=0. MSUB 1 x 1 from HI=LO=0 -> HI=LO=0xFFFFFFFF.
5. MULT 5 x 5 started, flush asserted 3 cycles later, prior HI=LO=0xAA -> busy drops next edge; HI/LO stay 0xAA.
6. Async reset asserted mid-DIV between clock edges -> busy=0 and HI=LO=0 immediately. start together with flush in IDLE -> no busy, no HI/LO change.
